// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: FSM state encoding, scancode constants, defaults.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_SC_BREAK = 8'hF0;
    localparam logic [7:0] PS2_SC_EXT   = 8'hE0;

    localparam int PS2_DEF_FIFO_DEPTH = 8;
    localparam int PS2_DEF_TIMEOUT    = 50000;

endpackage

// File: rtl/ps2_sc_fifo.sv
// First-word-fall-through scancode FIFO; head visible the cycle after a push, 8'h00 when empty.
// A push while full is accepted only if a pop frees a slot in the same cycle; otherwise it is ignored.
module ps2_sc_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic         o_empty,
    output logic         o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: sync + frame FSM + watchdog feeding a FWFT scancode FIFO popped on ps2_rd rising edge.
// Byte visible the cycle after its stop-bit fall; full FIFO drops and sets sticky overflow. Macro: PS2_BREAK_FILTER_EN.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = PS2_DEF_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = PS2_DEF_TIMEOUT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    input  logic       i_ps2_rd,
    output logic       o_ps2_ready,
    output logic [7:0] o_key_scan,
    output logic       o_overflow,
    output logic       o_frame_err
);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_t     r_state, w_next;
    logic           r_clk_s1, r_clk_s2, r_clk_s3;
    logic           r_dat_s1, r_dat_s2;
    logic           r_rd_prev;
    logic [2:0]     r_bit_cnt;
    logic [7:0]     r_shift;
    logic           r_parity;
    logic [WDW-1:0] r_wdog;
    logic           r_overflow;
    logic           w_fall, w_data, w_timeout;
    logic           w_frame_ok, w_frame_err;
    logic           w_push, w_pop, w_empty, w_full;

    assign w_fall    = r_clk_s3 & ~r_clk_s2;
    assign w_data    = r_dat_s2;
    assign w_pop     = i_ps2_rd & ~r_rd_prev;
    assign w_timeout = (r_state != ST_IDLE) && !w_fall && (r_wdog == WDW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_frame_ok  = 1'b0;
        w_frame_err = 1'b0;
        if (w_timeout) begin
            w_next      = ST_IDLE;
            w_frame_err = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE:   if (!w_data) w_next = ST_DATA;
                ST_DATA:   if (r_bit_cnt == 3'd7) w_next = ST_PARITY;
                ST_PARITY: w_next = ST_STOP;
                ST_STOP: begin
                    w_next = ST_IDLE;
                    if (w_data && (^{r_shift, r_parity})) w_frame_ok  = 1'b1;
                    else                                  w_frame_err = 1'b1;
                end
                default:   w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_s3   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_rd_prev  <= 1'b0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_wdog     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_clk_s1  <= i_ps2_clk;
            r_clk_s2  <= r_clk_s1;
            r_clk_s3  <= r_clk_s2;
            r_dat_s1  <= i_ps2_data;
            r_dat_s2  <= r_dat_s1;
            r_rd_prev <= i_ps2_rd;
            if (r_state == ST_IDLE || w_fall) r_wdog <= '0;
            else                              r_wdog <= r_wdog + 1'b1;
            if (w_fall && !w_timeout) begin
                case (r_state)
                    ST_IDLE:   r_bit_cnt <= '0;
                    ST_DATA: begin
                        r_shift   <= {w_data, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    ST_PARITY: r_parity <= w_data;
                    default:   ;
                endcase
            end
            // full FIFO only accepts the byte when a pop frees a slot this cycle
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

`ifdef PS2_BREAK_FILTER_EN
    logic r_brk_armed;

    // F0 and the byte after it are swallowed so only make codes reach the FIFO
    assign w_push = w_frame_ok && !r_brk_armed && (r_shift != PS2_SC_BREAK);

    always_ff @(posedge i_clk) begin
        if (i_rst)           r_brk_armed <= 1'b0;
        else if (w_frame_ok) r_brk_armed <= !r_brk_armed && (r_shift == PS2_SC_BREAK);
    end
`else
    assign w_push = w_frame_ok;
`endif

    ps2_sc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (r_shift),
        .o_dout  (o_key_scan),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign o_ps2_ready = !w_empty;
    assign o_overflow  = r_overflow;
    assign o_frame_err = w_frame_err;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: directed PS/2 frames plus a randomized phase against a queue-based model.
module tb_ps2_kbd_rx;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 300;
    localparam int HALF    = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ps2_rd;
    logic       ready;
    logic [7:0] key_scan;
    logic       overflow;
    logic       frame_err;

    int         n_cmp  = 0;
    int         n_fail = 0;
    int         fe_cnt = 0;
    int         exp_fe = 0;
    logic [7:0] m_q[$];
    logic       m_ovf  = 1'b0;
    logic       m_brk  = 1'b0;

    ps2_kbd_rx #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ps2_clk   (ps2_clk),
        .i_ps2_data  (ps2_data),
        .i_ps2_rd    (ps2_rd),
        .o_ps2_ready (ready),
        .o_key_scan  (key_scan),
        .o_overflow  (overflow),
        .o_frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_err === 1'b1) fe_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_rx(input logic [7:0] b);
`ifdef PS2_BREAK_FILTER_EN
        if (m_brk) begin
            m_brk = 1'b0;
            return;
        end
        if (b == 8'hF0) begin
            m_brk = 1'b1;
            return;
        end
`endif
        if (m_q.size() < DEPTH) m_q.push_back(b);
        else                    m_ovf = 1'b1;
    endtask

    task automatic check_head(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'(m_q.size() > 0));
        chk({tag, "_key"}, 32'(key_scan), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, "_ferr"}, 32'(fe_cnt), 32'(exp_fe));
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        ps2_clk = 1'b1; ps2_data = 1'b1; ps2_rd = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_q.delete();
        m_ovf = 1'b0;
        m_brk = 1'b0;
    endtask

    // nbits < 11 leaves a truncated frame; pop_at_stop raises ps2_rd in the stop-bit fall cycle
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input bit pop_at_stop);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk); #1 ps2_data = bits[i];
            repeat (HALF) @(posedge clk);
            #1 ps2_clk = 1'b0;
            if (i == 10 && pop_at_stop) begin
                repeat (2) @(posedge clk);
                #1 ps2_rd = 1'b1;
                repeat (3) @(posedge clk);
                #1 ps2_rd = 1'b0;
                repeat (HALF - 5) @(posedge clk);
            end else begin
                repeat (HALF) @(posedge clk);
            end
            #1 ps2_clk = 1'b1;
        end
        @(posedge clk); #1 ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
    endtask

    task automatic send_and_model(input logic [7:0] b, input bit bad, input string tag);
        send_frame(b, bad, 11, 1'b0);
        if (bad) exp_fe++;
        else     model_rx(b);
        @(negedge clk);
        check_head(tag);
    endtask

    task automatic do_pop(input int hold, input string tag);
        logic [7:0] exp_b;
        exp_b = (m_q.size() > 0) ? m_q[0] : 8'h00;
        @(posedge clk); #1 ps2_rd = 1'b1;
        @(negedge clk);
        chk({tag, "_rdval"}, 32'(key_scan), 32'(exp_b));
        repeat (hold) @(posedge clk);
        #1 ps2_rd = 1'b0;
        if (m_q.size() > 0) void'(m_q.pop_front());
        @(negedge clk);
        check_head(tag);
    endtask

    initial begin
        int lat;
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; ps2_rd = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_head("reset");

        // first frame: measure pin-fall to ready latency on the stop bit
        send_frame(8'h1C, 1'b0, 10, 1'b0);
        @(posedge clk); #1 ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (ready === 1'b1) break;
        end
        chk("stop_to_ready_latency", 32'(lat), 32'd4);
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (HALF) @(posedge clk);
        model_rx(8'h1C);
        @(negedge clk);
        check_head("frame_1c");
        do_pop(1, "pop_1c");
        do_pop(1, "pop_empty");

        send_and_model(8'h1C, 1'b1, "bad_parity");

        send_frame(8'hA5, 1'b0, 5, 1'b0);
        ps2_data = 1'b1;
        repeat (TIMEOUT + 50) @(posedge clk);
        exp_fe++;
        @(negedge clk);
        check_head("timeout");
        send_and_model(8'h32, 1'b0, "after_timeout");
        do_pop(1, "pop_32");

        send_frame(8'hAB, 1'b0, 6, 1'b0);
        do_reset();
        @(negedge clk);
        check_head("rst_mid");
        send_and_model(8'h4D, 1'b0, "after_rst");
        do_pop(1, "pop_4d");

        do_reset();
        for (int b = 1; b <= 9; b++) send_and_model(8'(b), 1'b0, "fill9");
        for (int i = 0; i < 8; i++) do_pop((i == 3) ? 5 : 1, "drain9");

        do_reset();
        for (int b = 8'h10; b <= 8'h17; b++) send_and_model(8'(b), 1'b0, "fill8");
        send_frame(8'h55, 1'b0, 11, 1'b1);
        void'(m_q.pop_front());
        model_rx(8'h55);
        @(negedge clk);
        check_head("push_pop_full");
        for (int i = 0; i < 8; i++) do_pop(1, "drain_pp");

        do_reset();
        send_and_model(8'h1C, 1'b0, "brk_a");
        send_and_model(8'hF0, 1'b0, "brk_b");
        send_and_model(8'h1C, 1'b0, "brk_c");
        send_and_model(8'hE0, 1'b0, "brk_d");
        send_and_model(8'h75, 1'b0, "brk_e");
        while (m_q.size() > 0) do_pop(1, "brk_drain");
        do_pop(1, "brk_empty");

        do_reset();
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0 && m_q.size() > 0)
                do_pop($urandom_range(1, 3), "rnd_pop");
            else
                send_and_model(8'($urandom), ($urandom_range(0, 7) == 0), "rnd_rx");
        end
        while (m_q.size() > 0) do_pop(1, "rnd_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_rx.md
# ps2_kbd_rx

PS/2 keyboard receiver and scancode buffer serving the bus decoder's keyboard window (0xFFFF_D000–0xFFFF_DFFF). It deserialises device-to-host PS/2 frames from the keyboard pins and checks each frame. Valid scancodes go into a small FIFO. The FIFO head is presented on `key_scan`, with `ps2_ready` indicating a byte is available. One byte is popped per CPU read access, signalled by the bus's `ps2_rd` strobe.

## Interface
- `FIFO_DEPTH`, 8: scancode FIFO entries; power of two, ≥ 2.
- `TIMEOUT_CYCLES`, 50000: max `clk` cycles between ps2_clk falling edges inside a frame before abort.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `ps2_clk`  in  1  keyboard clock pin, asynchronous.
- `ps2_data`  in  1  keyboard data pin, asynchronous.
- `ps2_rd`  in  1  pop request from bus; level, may stay high for several cycles per access.
- `ps2_ready`  out  1  FIFO non-empty.
- `key_scan`  out  8  FIFO head byte; 8'h00 when empty.
- `overflow`  out  1  sticky: a valid byte was dropped because the FIFO was full.
- `frame_err`  out  1  one-cycle pulse on any discarded frame.

## Operation
- `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser. A third flop on the clock path gives `fall` = synced_prev & ~synced. All sampling occurs only on cycles where `fall` is high.
- Frame format: start(0), 8 data bits LSB first, odd parity, stop(1).
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0 → DATA with bit count 0. Data=1 is ignored (stay IDLE, no error).
  - DATA: shift the data bit into the MSB of the shift register. After the 8th bit → PARITY.
  - PARITY: latch the bit → STOP.
  - STOP: on `fall`, the frame is valid iff stop=1 and ^{data,parity}=1. Valid → push. Invalid → `frame_err` pulse. Either way → IDLE.
- Watchdog: the counter resets on every `fall` and counts while not in IDLE. When it reaches TIMEOUT_CYCLES → IDLE with a `frame_err` pulse. A partial byte is never pushed.
- FIFO is first-word-fall-through, with occupancy count 0..FIFO_DEPTH.
- Pop: on the rising edge of `ps2_rd` (registered previous value), with exactly one pop per access however long `ps2_rd` is held. Pop when empty is ignored.
- Push when full: the byte is dropped and `overflow` is set. `overflow` clears only on `rst`.
- Simultaneous push and pop: both take effect and the count is unchanged. If full, the pop frees the slot, so the push succeeds and `overflow` is not set.
- Reset: FSM → IDLE, FIFO empty, pointers 0, synchronisers to 1 (bus idle). Resulting outputs: `ps2_ready`=0, `key_scan`=8'h00, `overflow`=0, `frame_err`=0.
- Reset mid-frame discards the partial frame; the next start bit is decoded normally.

## Timing
- Pin falling edge → `fall` pulse: 3 `clk` cycles.
- Stop-bit `fall` in cycle N → FIFO write at the end of N. `ps2_ready`/`key_scan` valid from N+1.
- `ps2_rd` rises in cycle M → pop at the end of M. The next head (or empty) is visible from M+1. During M, `key_scan` still shows the byte being read, so the CPU's combinational read returns it.
- `frame_err` is high for exactly cycle N (STOP fail) or for the watchdog-expiry cycle.
- `clk` must be ≥ 1 MHz so PS/2 half-periods (≥ 30 µs) span many cycles.

## Configuration
- `PS2_BREAK_FILTER_EN` defined: a valid 8'hF0 byte is not pushed and arms a flag. The next valid byte is also dropped and clears the flag. The FIFO therefore holds only make codes; 8'hE0 prefixes still pass through. The flag clears on `rst` and is unaffected by frame errors.
- Not defined: every valid byte is pushed verbatim, and no flag logic is present.

## Structure
- Shared package `ps2_pkg`: FSM state encoding (IDLE/DATA/PARITY/STOP), `PS2_SC_BREAK`=8'hF0, `PS2_SC_EXT`=8'hE0, default depth/timeout constants.
- Sub-module `ps2_sc_fifo`: parameterised FWFT FIFO (push, pop, din, dout, empty, full). The top level holds the synchroniser, FSM, watchdog, pop-edge detection and break filter.

## Test plan
- Send frame 0x1C (parity 0) → `ps2_ready`=1 and `key_scan`=0x1C starting N+1; single pop → `ps2_ready`=0, `key_scan`=0x00.
- Send frame 0x1C with parity bit 1 → `frame_err` pulses once, `ps2_ready` stays 0.
- Send 4 data bits, then idle TIMEOUT_CYCLES → `frame_err` pulse. A following frame 0x32 is received correctly.
- Send 9 bytes 0x01..0x09 (depth 8) without popping → `overflow`=1. Eight pops return 0x01..0x08. Hold `ps2_rd` high 5 cycles → only one pop.
- With FIFO full, pop in the same cycle as a push of 0x55 → count stays 8, `overflow` stays 0, 0x55 is last out.
- With `PS2_BREAK_FILTER_EN`, send 0x1C, 0xF0, 0x1C, 0xE0, 0x75 → FIFO yields 0x1C, 0xE0, 0x75. Without the macro, all five bytes appear.
